// File: rtl/cpri_tx_pkg_arb.sv
// cpri_tx_pkg_arb: packet-level round-robin arbiter sharing one CPRI TX buffer write port.
// Define CPRI_TX_ARB_STAT_EN to add saturating packet/error statistics outputs.
module cpri_tx_pkg_arb #(
    parameter int NREQ        = 4,
    parameter int PKT_LEN_MAX = 128,
    parameter int TIMEOUT     = 1024,
    parameter int GAP_CYC     = 1
) (
    input  logic                 sys_clk_491_52,
    input  logic                 sys_rst_491_52,
    input  logic [NREQ-1:0]      i_req,
    output logic [NREQ-1:0]      o_gnt,
    input  logic [NREQ-1:0]      i_wen,
    input  logic [NREQ*64-1:0]   i_wdata,
    input  logic [NREQ-1:0]      i_wlast,
    input  logic                 i_tx_ready,
    output logic                 o_cpri_wen,
    output logic [6:0]           o_cpri_waddr,
    output logic [63:0]          o_cpri_wdata,
    output logic                 o_cpri_wlast,
    output logic                 o_busy,
    output logic                 o_err_len,
    output logic                 o_err_tmo
`ifdef CPRI_TX_ARB_STAT_EN
    ,
    output logic [NREQ*16-1:0]   o_pkt_cnt,
    output logic [15:0]          o_err_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [6:0]    LAST_IDX = 7'(PKT_LEN_MAX - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1'b1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1'b1);
    localparam logic [NREQ-1:0] GNT_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [6:0]      wcnt_q, wcnt_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            wen_q, wen_d;
    logic [6:0]      waddr_q, waddr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            wlast_q, wlast_d;
    logic            elen_q, elen_d;
    logic            etmo_q, etmo_d;
    logic            busy_q;

    logic [63:0]     wdata_arr_s [NREQ];
    logic [PW-1:0]   cand_s;
    logic [PW-1:0]   win_idx_s;
    logic            win_found_s;
    logic            sel_wen_s;
    logic            sel_wlast_s;
    logic [63:0]     sel_wdata_s;

    // Split the flat data bus into per-requester words.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            wdata_arr_s[k] = i_wdata[64*k +: 64];
        end
    end

    // Granted requester's write strobe, last flag and data.
    always_comb begin
        sel_wen_s   = i_wen[gidx_q];
        sel_wlast_s = i_wlast[gidx_q];
        sel_wdata_s = wdata_arr_s[gidx_q];
    end

    // Round-robin search: first active request after the last winner, with wrap.
    always_comb begin
        cand_s      = {PW{1'b0}};
        win_idx_s   = {PW{1'b0}};
        win_found_s = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_s = PW'((int'(ptr_q) + i) % NREQ);
            if (!win_found_s && i_req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Packet FSM next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        wcnt_d  = wcnt_q;
        idle_d  = idle_q;
        gap_d   = gap_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wlast_d = 1'b0;
        elen_d  = 1'b0;
        etmo_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_tx_ready && win_found_s) begin
                    gnt_d   = GNT_ONE << win_idx_s;
                    ptr_d   = win_idx_s;
                    gidx_d  = win_idx_s;
                    wcnt_d  = 7'd0;
                    idle_d  = {TW{1'b0}};
                    state_d = ST_XFER;
                end else begin
                    gnt_d   = {NREQ{1'b0}};
                end
            end
            ST_XFER: begin
                if (sel_wen_s) begin
                    idle_d  = {TW{1'b0}};
                    wen_d   = 1'b1;
                    waddr_d = wcnt_q;
                    wdata_d = sel_wdata_s;
                    if (sel_wlast_s) begin
                        wlast_d = 1'b1;
                        gnt_d   = {NREQ{1'b0}};
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else if (wcnt_q == LAST_IDX) begin
                        // Truncate: close the packet downstream, keep the grant to swallow the tail.
                        wlast_d = 1'b1;
                        elen_d  = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        wcnt_d  = wcnt_q + 7'd1;
                    end
                end else if (idle_q == TMO_LAST) begin
                    etmo_d  = 1'b1;
                    gnt_d   = {NREQ{1'b0}};
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    idle_d  = idle_q + TMO_ONE;
                end
            end
            ST_DRAIN: begin
                if (sel_wen_s) begin
                    idle_d = {TW{1'b0}};
                    if (sel_wlast_s) begin
                        gnt_d   = {NREQ{1'b0}};
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (idle_q == TMO_LAST) begin
                    etmo_d  = 1'b1;
                    gnt_d   = {NREQ{1'b0}};
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    idle_d  = idle_q + TMO_ONE;
                end
            end
            ST_GAP: begin
                if (gap_q == {GW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = gap_q - GAP_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {NREQ{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk_491_52 or posedge sys_rst_491_52) begin
        if (sys_rst_491_52) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            gidx_q  <= {PW{1'b0}};
            gnt_q   <= {NREQ{1'b0}};
            wcnt_q  <= 7'd0;
            idle_q  <= {TW{1'b0}};
            gap_q   <= {GW{1'b0}};
            wen_q   <= 1'b0;
            waddr_q <= 7'd0;
            wdata_q <= 64'd0;
            wlast_q <= 1'b0;
            elen_q  <= 1'b0;
            etmo_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            wcnt_q  <= wcnt_d;
            idle_q  <= idle_d;
            gap_q   <= gap_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wlast_q <= wlast_d;
            elen_q  <= elen_d;
            etmo_q  <= etmo_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign o_gnt        = gnt_q;
    assign o_cpri_wen   = wen_q;
    assign o_cpri_waddr = waddr_q;
    assign o_cpri_wdata = wdata_q;
    assign o_cpri_wlast = wlast_q;
    assign o_busy       = busy_q;
    assign o_err_len    = elen_q;
    assign o_err_tmo    = etmo_q;

`ifdef CPRI_TX_ARB_STAT_EN
    logic [15:0] pkt_cnt_q [NREQ];
    logic [15:0] err_cnt_q;
    logic        pkt_done_s;

    // A packet counts as completed when its producer delivers wlast under grant.
    always_comb begin
        if ((state_q == ST_XFER) || (state_q == ST_DRAIN)) begin
            pkt_done_s = sel_wen_s & sel_wlast_s;
        end else begin
            pkt_done_s = 1'b0;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge sys_clk_491_52 or posedge sys_rst_491_52) begin
        if (sys_rst_491_52) begin
            for (int k = 0; k < NREQ; k++) begin
                pkt_cnt_q[k] <= 16'd0;
            end
            err_cnt_q <= 16'd0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (pkt_done_s && (gidx_q == PW'(k)) && (pkt_cnt_q[k] != 16'hFFFF)) begin
                    pkt_cnt_q[k] <= pkt_cnt_q[k] + 16'd1;
                end
            end
            if ((elen_d || etmo_d) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // Flatten per-requester counters onto the output bus.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            o_pkt_cnt[16*k +: 16] = pkt_cnt_q[k];
        end
    end

    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_cpri_tx_pkg_arb.sv
// Randomized bench for cpri_tx_pkg_arb against a packet-level reference model.
`timescale 1ns/1ps
module tb_cpri_tx_pkg_arb;

    localparam int NREQ        = 4;
    localparam int PKT_LEN_MAX = 128;
    localparam int TIMEOUT     = 1024;
    localparam int GAP_CYC     = 1;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     wen;
    logic [NREQ*64-1:0]  wdata;
    logic [NREQ-1:0]     wlast;
    logic                tx_ready;
    logic                c_wen;
    logic [6:0]          c_waddr;
    logic [63:0]         c_wdata;
    logic                c_wlast;
    logic                busy;
    logic                err_len;
    logic                err_tmo;

    cpri_tx_pkg_arb #(
        .NREQ(NREQ), .PKT_LEN_MAX(PKT_LEN_MAX), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
    ) dut (
        .sys_clk_491_52(clk), .sys_rst_491_52(rst),
        .i_req(req), .o_gnt(gnt), .i_wen(wen), .i_wdata(wdata), .i_wlast(wlast),
        .i_tx_ready(tx_ready),
        .o_cpri_wen(c_wen), .o_cpri_waddr(c_waddr), .o_cpri_wdata(c_wdata),
        .o_cpri_wlast(c_wlast), .o_busy(busy), .o_err_len(err_len), .o_err_tmo(err_tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: current grant, rr pointer, word index, quiet cycles, earliest decision cycle
    int m_cur, m_ptr, m_words, m_quiet, m_free;
    bit m_drain;
    logic [NREQ-1:0] e_gnt;
    logic e_wen, e_last, e_elen, e_etmo, e_busy;
    logic [63:0] e_data;
    logic [6:0]  e_addr;

    // producers
    bit pend [NREQ];
    bit mute [NREQ];
    int plen [NREQ];
    int psent[NREQ];
    int wen_pct, noise_pct, refill_pct, ready_pct, mute_pm, fixed_len;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = -1; m_ptr = NREQ - 1; m_free = 0; m_words = 0; m_quiet = 0; m_drain = 1'b0;
        e_gnt = '0; e_wen = 1'b0; e_last = 1'b0; e_elen = 1'b0; e_etmo = 1'b0; e_busy = 1'b0;
        e_data = 64'd0; e_addr = 7'd0;
        for (int k = 0; k < NREQ; k++) begin
            pend[k] = 1'b0; mute[k] = 1'b0; plen[k] = 0; psent[k] = 0;
        end
        req = '0; wen = '0; wlast = '0; wdata = '0; tx_ready = 1'b0;
    endtask

    task automatic add_pkt(input int k, input int len, input bit mt);
        pend[k] = 1'b1; plen[k] = len; psent[k] = 0; mute[k] = mt;
    endtask

    task automatic end_pkt();
        m_cur = -1;
        e_gnt = '0;
        m_free = cyc + GAP_CYC + 1;
    endtask

    task automatic drive_inputs();
        wen = '0; wlast = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pend[k] && m_cur != k && $urandom_range(99) < refill_pct) begin
                add_pkt(k, (fixed_len > 0) ? fixed_len : int'($urandom_range(140, 1)),
                        $urandom_range(999) < mute_pm);
            end
            wdata[64*k +: 64] = {$urandom, $urandom};
            if (m_cur == k) begin
                if (pend[k] && !mute[k] && psent[k] < plen[k] && $urandom_range(99) < wen_pct) begin
                    wen[k]   = 1'b1;
                    wlast[k] = (psent[k] == plen[k] - 1);
                    psent[k]++;
                    if (wlast[k]) pend[k] = 1'b0;
                end
            end else if ($urandom_range(99) < noise_pct) begin
                wen[k]   = 1'b1;
                wlast[k] = 1'($urandom_range(1));
            end
            req[k] = pend[k];
        end
        tx_ready = ($urandom_range(99) < ready_pct);
    endtask

    // Predict what the DUT shows after the coming edge.
    task automatic model_edge();
        int g;
        bit found;
        e_wen = 1'b0; e_last = 1'b0; e_elen = 1'b0; e_etmo = 1'b0;
        if (m_cur < 0) begin
            if (cyc >= m_free && tx_ready && req != '0) begin
                found = 1'b0;
                for (int i = 1; i <= NREQ; i++) begin
                    if (!found && req[(m_ptr + i) % NREQ]) begin
                        found = 1'b1;
                        m_cur = (m_ptr + i) % NREQ;
                    end
                end
                m_ptr = m_cur; m_words = 0; m_quiet = 0; m_drain = 1'b0;
                e_gnt = '0;
                e_gnt[m_cur] = 1'b1;
            end
        end else begin
            g = m_cur;
            if (wen[g]) begin
                m_quiet = 0;
                if (!m_drain) begin
                    e_wen  = 1'b1;
                    e_data = wdata[64*g +: 64];
                    e_addr = 7'(m_words);
                    if (wlast[g]) begin
                        e_last = 1'b1;
                        end_pkt();
                    end else if (m_words == PKT_LEN_MAX - 1) begin
                        e_last = 1'b1; e_elen = 1'b1; m_drain = 1'b1;
                    end else begin
                        m_words++;
                    end
                end else if (wlast[g]) begin
                    end_pkt();
                end
            end else begin
                m_quiet++;
                if (m_quiet == TIMEOUT) begin
                    e_etmo = 1'b1;
                    pend[g] = 1'b0;
                    end_pkt();
                end
            end
        end
        e_busy = (m_cur >= 0) || (cyc < m_free - 1);
    endtask

    task automatic step();
        @(negedge clk);
        check_val("gnt", gnt, e_gnt);
        check_val("busy", busy, e_busy);
        check_val("wen", c_wen, e_wen);
        check_val("wlast", c_wlast, e_last);
        check_val("err_len", err_len, e_elen);
        check_val("err_tmo", err_tmo, e_etmo);
        if (e_wen) begin
            check_val("wdata", c_wdata, e_data);
            check_val("waddr", c_waddr, e_addr);
        end
        drive_inputs();
        model_edge();
        cyc++;
    endtask

    function automatic bit model_quiet();
        bit q;
        q = (m_cur < 0) && (cyc >= m_free);
        for (int k = 0; k < NREQ; k++) if (pend[k]) q = 1'b0;
        return q;
    endfunction

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (!model_quiet() && n < budget) begin
            step();
            n++;
        end
        check_val("idle_budget", model_quiet(), 1'b1);
        repeat (3) step();
    endtask

    task automatic set_knobs(input int wp, input int np, input int rp, input int tp,
                             input int mp, input int fl);
        wen_pct = wp; noise_pct = np; refill_pct = rp; ready_pct = tp; mute_pm = mp; fixed_len = fl;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_gnt"}, gnt, '0);
        check_val({tag, "_wen"}, c_wen, 1'b0);
        check_val({tag, "_waddr"}, c_waddr, 7'd0);
        check_val({tag, "_wdata"}, c_wdata, 64'd0);
        check_val({tag, "_wlast"}, c_wlast, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_elen"}, err_len, 1'b0);
        check_val({tag, "_etmo"}, err_tmo, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        model_reset();
        set_knobs(100, 0, 0, 100, 0, 0);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // two requesters, req0 6 words then req2 3 words
        add_pkt(0, 6, 1'b0);
        add_pkt(2, 3, 1'b0);
        run_until_idle(100);

        // continuous 3-word packets from all requesters
        set_knobs(100, 0, 100, 100, 0, 3);
        repeat (40) step();
        set_knobs(100, 0, 0, 100, 0, 0);
        run_until_idle(100);

        // boundaries: 1-word, exactly PKT_LEN_MAX, overlong, with noise on others
        set_knobs(100, 30, 0, 100, 0, 0);
        add_pkt(3, 1, 1'b0);
        add_pkt(0, PKT_LEN_MAX, 1'b0);
        add_pkt(1, PKT_LEN_MAX + 2, 1'b0);
        run_until_idle(600);

        // stalled requester times out, next one still served
        set_knobs(100, 0, 0, 100, 0, 0);
        add_pkt(2, 5, 1'b1);
        add_pkt(3, 4, 1'b0);
        run_until_idle(TIMEOUT + 100);

        // random traffic
        set_knobs(70, 20, 5, 80, 3, 0);
        repeat (4000) step();
        set_knobs(70, 20, 0, 80, 0, 0);
        run_until_idle(8000);

        // reset in the middle of a packet
        set_knobs(100, 0, 0, 100, 0, 0);
        add_pkt(1, 10, 1'b0);
        n = 0;
        while (psent[1] < 4 && n < 200) begin
            step();
            n++;
        end
        check_val("mid_pkt_reached", psent[1] >= 4, 1'b1);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_rst");
        @(negedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        add_pkt(2, 2, 1'b0);
        add_pkt(0, 2, 1'b0);
        n = 0;
        while (gnt == '0 && n < 20) begin
            step();
            n++;
        end
        check_val("rst_first_gnt", gnt, 4'b0001);
        run_until_idle(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
